// File: rtl/mac_row_flex.sv
// mac_row_flex: systolic MAC row with one 4-bit (mode 1) or two 2-bit-activation (mode 0) signed weights per column.
// Define MAC_ROW_SAT_EN to make the column adders saturate instead of wrapping.
module mac_row_flex #(
  parameter int bw      = 2,
  parameter int psum_bw = 32,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          in_w0,
  input  logic [bw-1:0]          in_w1,
  input  logic [2:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic                   load_done
);
  localparam int WB = 2*bw;
  localparam int CB = $clog2(col);
  localparam int PB = CB + 1;
  localparam int MW = 4*bw + 2;
  logic load, exec, mode, mode_flip, last, accept;
  logic mode_q, mode_d, load_done_q, load_done_d;
  logic [PB-1:0] ptr_q, ptr_d, p;
  logic [CB-1:0] idx;
  logic signed [WB-1:0] w_lo_q [col];
  logic signed [WB-1:0] w_hi_q [col];
  logic [col-1:0] st_v_q, st_m_q, valid_q;
  logic [WB-1:0] st_a_q [col];
  logic [psum_bw*col-1:0] out_q;
  assign {mode, exec, load} = inst_w;
  assign out_s     = out_q;
  assign valid     = valid_q;
  assign load_done = load_done_q;
  function automatic logic signed [psum_bw-1:0] mac(
    input logic                      m,
    input logic [WB-1:0]             a,
    input logic signed [WB-1:0]      wl,
    input logic signed [WB-1:0]      wh,
    input logic signed [psum_bw-1:0] n
  );
    logic signed [MW-1:0] pr;
    logic signed [psum_bw-1:0] pe, s;
    pr = m ? $signed(MW'(a)) * MW'(wl)
           : $signed(MW'(a[bw-1:0])) * MW'(wl) + $signed(MW'(a[WB-1:bw])) * MW'(wh);
    pe = psum_bw'(pr);
    s  = n + pe;
`ifdef MAC_ROW_SAT_EN
    if (n[psum_bw-1] == pe[psum_bw-1] && s[psum_bw-1] != n[psum_bw-1])
      s = n[psum_bw-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
`endif
    return s;
  endfunction
  // A finished sequence or a mode change makes the current beat start again from pointer 0.
  always_comb begin
    mode_flip   = (load | exec) & (mode != mode_q);
    p           = (load_done_q | mode_flip) ? '0 : ptr_q;
    last        = mode ? (p == PB'(col-1)) : (p == PB'(2*col-1));
    idx         = mode ? p[CB-1:0] : p[CB:1];
    accept      = exec & ~load & load_done_q & ~mode_flip;
    ptr_d       = load ? (last ? p : p + 1'b1) : (mode_flip ? '0 : ptr_q);
    load_done_d = load ? last : load_done_q & ~mode_flip;
    mode_d      = load ? mode : mode_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= '0;
      load_done_q <= 1'b0;
      mode_q      <= 1'b0;
      for (int c = 0; c < col; c++) begin
        w_lo_q[c] <= '0;
        w_hi_q[c] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      load_done_q <= load_done_d;
      mode_q      <= mode_d;
      if (load && (mode || !p[0])) w_lo_q[idx] <= $signed({in_w1, in_w0});
      if (load && !mode && p[0])   w_hi_q[idx] <= $signed({in_w1, in_w0});
    end
  end
  // Each beat carries its own mode and activation down the row, one column per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_v_q  <= '0;
      st_m_q  <= '0;
      valid_q <= '0;
      out_q   <= '0;
      for (int c = 0; c < col; c++) st_a_q[c] <= '0;
    end else begin
      st_v_q    <= {st_v_q[col-2:0], accept};
      st_m_q    <= {st_m_q[col-2:0], mode};
      st_a_q[0] <= {in_w1, in_w0};
      for (int c = 1; c < col; c++) st_a_q[c] <= st_a_q[c-1];
      valid_q <= st_v_q;
      for (int c = 0; c < col; c++)
        if (st_v_q[c])
          out_q[c*psum_bw +: psum_bw] <= mac(st_m_q[c], st_a_q[c], w_lo_q[c], w_hi_q[c],
                                             $signed(in_n[c*psum_bw +: psum_bw]));
    end
  end
endmodule

// File: tb/tb_mac_row_flex.sv
// tb_mac_row_flex: scoreboard bench for mac_row_flex (4 columns); expectations follow MAC_ROW_SAT_EN.
module tb_mac_row_flex;
  localparam int BW = 2, PW = 32, COL = 4;
  logic clk = 0, reset = 0;
  logic [BW-1:0] in_w0 = 0, in_w1 = 0;
  logic [2:0] inst_w = 0;
  logic [PW*COL-1:0] in_n = 0;
  logic [PW*COL-1:0] out_s;
  logic [COL-1:0] valid;
  logic load_done;
  typedef struct {int c; int cyc; logic [31:0] v;} exp_t;
  exp_t sbq[$];
  int compared = 0, mism = 0, cyc = 0;
  logic cm = 0;
  logic [3:0] wlo[COL], whi[COL], ldw[16];
  logic [PW*COL-1:0] snap;

  mac_row_flex #(.bw(BW), .psum_bw(PW), .col(COL)) dut (
    .clk(clk), .reset(reset), .in_w0(in_w0), .in_w1(in_w1), .inst_w(inst_w),
    .in_n(in_n), .out_s(out_s), .valid(valid), .load_done(load_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic m, input logic [3:0] a, input int c, input logic [31:0] n);
    int wl, wh, av, a0, a1, pr;
    longint s;
    wl = $signed(wlo[c]); wh = $signed(whi[c]);
    av = a; a0 = a[1:0]; a1 = a[3:2];
    pr = m ? av * wl : a0 * wl + a1 * wh;
    s = $signed(n);
    s = s + pr;
`ifdef MAC_ROW_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  function automatic void model_load(input logic m, input int i, input logic [3:0] w);
    if (m) wlo[i] = w;
    else if (i % 2 == 1) whi[i/2] = w;
    else wlo[i/2] = w;
  endfunction

  task automatic idle();
    inst_w = {cm, 2'b00}; in_w0 = 0; in_w1 = 0;
  endtask

  task automatic drive_exec(input logic [3:0] a);
    inst_w = {cm, 2'b10}; {in_w1, in_w0} = a;
    for (int c = 0; c < COL; c++) sbq.push_back('{c, cyc + 2 + c, model(cm, a, c, in_n[c*PW +: PW])});
  endtask

  task automatic do_load(input logic m, input int n);
    cm = m;
    for (int i = 0; i < n; i++) begin
      inst_w = {m, 2'b01}; {in_w1, in_w0} = ldw[i];
      model_load(m, i, ldw[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    inst_w = 3'b101; {in_w1, in_w0} = 4'h7; in_n = '1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (out_s !== '0) begin mism++; $display("FAIL reset_out_s: got %h, required 0", out_s); end
    compared++; if (valid !== '0) begin mism++; $display("FAIL reset_valid: got %b, required 0", valid); end
    compared++; if (load_done !== 1'b0) begin mism++; $display("FAIL reset_load_done: got %b, required 0", load_done); end
    for (int c = 0; c < COL; c++) begin wlo[c] = 0; whi[c] = 0; end
    reset = 1; cm = 0; in_n = '0;
    for (int t = 0; t < 5; t++) begin
      if (t < 2) inst_w = 3'b010; else idle();
      @(posedge clk); #1;
      compared++; if (valid !== '0) begin mism++; $display("FAIL exec_before_load t%0d: valid %b, required 0", t, valid); end
    end
  endtask

  task automatic test_mode1_exec();
    ldw[0] = 4'h1; ldw[1] = 4'hE; ldw[2] = 4'h7; ldw[3] = 4'h8;
    in_n = '0;
    do_load(1, COL);
    compared++; if (load_done !== 1'b1) begin mism++; $display("FAIL m1_load_done: got %b, required 1", load_done); end
    for (int t = 0; t < 1 + COL + 2; t++) begin
      if (t < 1) drive_exec(4'd3); else idle();
      @(posedge clk); #1;
      for (int c = 0; c < COL; c++) if (valid[c]) begin
        int k = -1;
        for (int i = 0; i < sbq.size(); i++) if (sbq[i].c == c) begin k = i; break; end
        compared++;
        if (k < 0) begin mism++; $display("FAIL m1_exec col %0d: valid at cycle %0d, required no pulse", c, cyc); end
        else begin
          if (out_s[c*PW +: PW] !== sbq[k].v || cyc != sbq[k].cyc) begin
            mism++; $display("FAIL m1_exec col %0d: out_s=%0d at cycle %0d, required %0d at cycle %0d",
                             c, $signed(out_s[c*PW +: PW]), cyc, $signed(sbq[k].v), sbq[k].cyc);
          end
          sbq.delete(k);
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mism++; $display("FAIL m1_exec_missing: %0d outputs not seen, required 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_mode0_exec();
    ldw[0] = 4'h1; ldw[1] = 4'h2; ldw[2] = 4'hF; ldw[3] = 4'h3;
    ldw[4] = 4'h8; ldw[5] = 4'h7; ldw[6] = 4'h5; ldw[7] = 4'hC;
    in_n = {32'd0, 32'd1000, 32'hFFFFFFFD, 32'd10};
    do_load(0, 2*COL);
    compared++; if (load_done !== 1'b1) begin mism++; $display("FAIL m0_load_done: got %b, required 1", load_done); end
    for (int t = 0; t < 1 + COL + 2; t++) begin
      if (t < 1) drive_exec(4'b1011); else idle();
      @(posedge clk); #1;
      for (int c = 0; c < COL; c++) if (valid[c]) begin
        int k = -1;
        for (int i = 0; i < sbq.size(); i++) if (sbq[i].c == c) begin k = i; break; end
        compared++;
        if (k < 0) begin mism++; $display("FAIL m0_exec col %0d: valid at cycle %0d, required no pulse", c, cyc); end
        else begin
          if (out_s[c*PW +: PW] !== sbq[k].v || cyc != sbq[k].cyc) begin
            mism++; $display("FAIL m0_exec col %0d: out_s=%0d at cycle %0d, required %0d at cycle %0d",
                             c, $signed(out_s[c*PW +: PW]), cyc, $signed(sbq[k].v), sbq[k].cyc);
          end
          sbq.delete(k);
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mism++; $display("FAIL m0_exec_missing: %0d outputs not seen, required 0", sbq.size()); end
    sbq.delete();
    compared++; if (out_s[PW-1:0] !== 32'd17) begin mism++; $display("FAIL m0_col0_value: got %0d, required 17", out_s[PW-1:0]); end
  endtask

  task automatic test_load_sequence();
    snap = out_s;
    inst_w = 3'b110;
    @(posedge clk); #1;
    compared++; if (load_done !== 1'b0) begin mism++; $display("FAIL flip_clears_done: got %b, required 0", load_done); end
    inst_w = 3'b010;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      idle();
      compared++; if (valid !== '0) begin mism++; $display("FAIL flip_drop_valid t%0d: got %b, required 0", t, valid); end
      compared++; if (out_s !== snap) begin mism++; $display("FAIL flip_drop_out_s t%0d: got %h, required %h", t, out_s, snap); end
    end
    cm = 1;
    ldw[0] = 4'h2; ldw[1] = 4'h3; ldw[2] = 4'h4; ldw[3] = 4'h5;
    for (int i = 0; i < COL; i++) begin
      inst_w = 3'b101; {in_w1, in_w0} = ldw[i]; model_load(1, i, ldw[i]);
      @(posedge clk); #1;
      compared++; if (load_done !== (i == COL-1)) begin mism++; $display("FAIL m1_reload beat %0d: load_done %b, required %b", i, load_done, i == COL-1); end
      if (i == 1) begin
        inst_w = 3'b110;
        @(posedge clk); #1;
        idle();
        compared++; if (valid !== '0 || load_done !== 1'b0) begin mism++; $display("FAIL early_exec: valid %b done %b, required 0 0", valid, load_done); end
        @(posedge clk); #1;
        compared++; if (valid !== '0) begin mism++; $display("FAIL early_exec_late: valid %b, required 0", valid); end
      end
    end
    cm = 0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 2*COL; i++) begin
        inst_w = 3'b001; {in_w1, in_w0} = 4'(i + 3*r); model_load(0, i, 4'(i + 3*r));
        @(posedge clk); #1;
        compared++; if (load_done !== (i == 2*COL-1)) begin mism++; $display("FAIL m0_reload r%0d beat %0d: load_done %b, required %b", r, i, load_done, i == 2*COL-1); end
      end
    idle();
  endtask

  task automatic test_overflow();
    ldw[0] = 4'h7; ldw[1] = 4'h8; ldw[2] = 4'h7; ldw[3] = 4'h8;
    in_n = {32'h7FFFFFF0, 32'h80000005, 32'h80000000, 32'h7FFFFFFF};
    do_load(1, COL);
    for (int t = 0; t < 1 + COL + 2; t++) begin
      if (t < 1) drive_exec(4'd15); else idle();
      @(posedge clk); #1;
      for (int c = 0; c < COL; c++) if (valid[c]) begin
        int k = -1;
        for (int i = 0; i < sbq.size(); i++) if (sbq[i].c == c) begin k = i; break; end
        compared++;
        if (k < 0) begin mism++; $display("FAIL ovf col %0d: valid at cycle %0d, required no pulse", c, cyc); end
        else begin
          if (out_s[c*PW +: PW] !== sbq[k].v || cyc != sbq[k].cyc) begin
            mism++; $display("FAIL ovf col %0d: out_s=%h at cycle %0d, required %h at cycle %0d",
                             c, out_s[c*PW +: PW], cyc, sbq[k].v, sbq[k].cyc);
          end
          sbq.delete(k);
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mism++; $display("FAIL ovf_missing: %0d outputs not seen, required 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_back_to_back();
    ldw[0] = 4'h3; ldw[1] = 4'hB; ldw[2] = 4'hF; ldw[3] = 4'h6;
    in_n = {32'hFFFF0000, 32'h7FFFFFF0, 32'hFFFFFFF9, 32'd100};
    do_load(1, COL);
    for (int t = 0; t < 16 + COL + 2; t++) begin
      if (t < 16) drive_exec(4'(t)); else idle();
      @(posedge clk); #1;
      for (int c = 0; c < COL; c++) if (valid[c]) begin
        int k = -1;
        for (int i = 0; i < sbq.size(); i++) if (sbq[i].c == c) begin k = i; break; end
        compared++;
        if (k < 0) begin mism++; $display("FAIL b2b col %0d: valid at cycle %0d, required no pulse", c, cyc); end
        else begin
          if (out_s[c*PW +: PW] !== sbq[k].v || cyc != sbq[k].cyc) begin
            mism++; $display("FAIL b2b col %0d: out_s=%0d at cycle %0d, required %0d at cycle %0d",
                             c, $signed(out_s[c*PW +: PW]), cyc, $signed(sbq[k].v), sbq[k].cyc);
          end
          sbq.delete(k);
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mism++; $display("FAIL b2b_missing: %0d outputs not seen, required 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_reset_midstream();
    in_n = {32'd5, 32'd6, 32'd7, 32'd8};
    for (int t = 0; t < 6; t++) begin
      inst_w = 3'b110; {in_w1, in_w0} = 4'(t + 1);
      @(posedge clk); #1;
    end
    reset = 0;
    @(posedge clk); #1;
    compared++; if (valid !== '0) begin mism++; $display("FAIL midreset_valid: got %b, required 0", valid); end
    compared++; if (out_s !== '0) begin mism++; $display("FAIL midreset_out_s: got %h, required 0", out_s); end
    compared++; if (load_done !== 1'b0) begin mism++; $display("FAIL midreset_load_done: got %b, required 0", load_done); end
    reset = 1; cm = 0; idle();
    for (int t = 0; t < COL + 1; t++) begin
      @(posedge clk); #1;
      compared++; if (valid !== '0) begin mism++; $display("FAIL midreset_flush t%0d: valid %b, required 0", t, valid); end
    end
  endtask

  initial begin
    test_reset();
    test_mode1_exec();
    test_mode0_exec();
    test_load_sequence();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
